// File: rtl/timer_bank.sv
// timer_bank: multi-channel programmable interval timer behind an 8-bit register port.
// Build option TIMER_BANK_FASTCLK_EN adds a per-channel FAST bit (CTRL[4]) that counts every clk.
module timer_bank #(
    parameter int unsigned              CHANNELS      = 4,
    parameter int unsigned              COUNTER_WIDTH = 16,
    parameter int unsigned              DIVIDER_WIDTH = 15,
    parameter logic [DIVIDER_WIDTH-1:0] INTERVAL      = 15'd24000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [$clog2(CHANNELS)+2:0]   addr,
    input  logic                          wr,
    input  logic                          rd,
    input  logic [7:0]                    din,
    output logic [7:0]                    dout,
    output logic                          irq
);

    localparam int unsigned ADDR_W = $clog2(CHANNELS) + 3;
    localparam int unsigned HI_W   = COUNTER_WIDTH - 8;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_CNT_LO = 3'd2;
    localparam logic [2:0] REG_CNT_HI = 3'd3;
    localparam logic [2:0] REG_CMP_LO = 3'd4;
    localparam logic [2:0] REG_CMP_HI = 3'd5;

    logic [DIVIDER_WIDTH-1:0] presc;
    logic                     tick_c;
    logic [2:0]               reg_sel_c;
    logic [ADDR_W-1:0]        ch_sel_c;
    logic [7:0]               ch_rdata [CHANNELS];
    logic [CHANNELS-1:0]      irq_terms;
    logic [7:0]               rd_mux_c;

    assign reg_sel_c = addr[2:0];
    assign ch_sel_c  = addr >> 3;
    assign tick_c    = (presc == INTERVAL);

    // Shared prescaler: one-clock tick every INTERVAL+1 clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (tick_c) begin
            presc <= '0;
        end else begin
            presc <= presc + DIVIDER_WIDTH'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [COUNTER_WIDTH-1:0] cnt;
        logic [COUNTER_WIDTH-1:0] cmp;
        logic [7:0]               cmp_lo_buf;
        logic [HI_W-1:0]          cnt_hi_shadow;
        logic                     en;
        logic                     oneshot;
        logic                     irq_en;
        logic                     flag;
        logic                     fast;
        logic                     sel_c;
        logic                     wr_ctrl_c;
        logic                     wr_status_c;
        logic                     wr_cmp_lo_c;
        logic                     wr_cmp_hi_c;
        logic                     rd_cnt_lo_c;
        logic                     step_c;
        logic                     match_c;
        logic [7:0]               rdata_c;

        assign sel_c       = (ch_sel_c == ADDR_W'(i));
        assign wr_ctrl_c   = wr && sel_c && (reg_sel_c == REG_CTRL);
        assign wr_status_c = wr && sel_c && (reg_sel_c == REG_STATUS);
        assign wr_cmp_lo_c = wr && sel_c && (reg_sel_c == REG_CMP_LO);
        assign wr_cmp_hi_c = wr && sel_c && (reg_sel_c == REG_CMP_HI);
        assign rd_cnt_lo_c = rd && sel_c && (reg_sel_c == REG_CNT_LO);

`ifdef TIMER_BANK_FASTCLK_EN
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                fast <= 1'b0;
            end else if (wr_ctrl_c) begin
                fast <= din[4];
            end
        end
`else
        assign fast = 1'b0;
`endif

        assign step_c  = en && (tick_c || fast);
        assign match_c = (cnt == cmp);

        // Later assignments encode priority: CPU writes over counting, flag set over W1C
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt           <= '0;
                cmp           <= '0;
                cmp_lo_buf    <= '0;
                cnt_hi_shadow <= '0;
                en            <= 1'b0;
                oneshot       <= 1'b0;
                irq_en        <= 1'b0;
                flag          <= 1'b0;
            end else begin
                if (step_c) begin
                    if (match_c) begin
                        if (oneshot) begin
                            en <= 1'b0;
                        end else begin
                            cnt <= '0;
                        end
                    end else begin
                        cnt <= cnt + COUNTER_WIDTH'(1);
                    end
                end
                if (wr_ctrl_c) begin
                    en      <= din[0];
                    oneshot <= din[1];
                    irq_en  <= din[2];
                    if (din[3]) begin
                        cnt <= '0;
                    end
                end
                if (wr_status_c && din[0]) begin
                    flag <= 1'b0;
                end
                if (step_c && match_c) begin
                    flag <= 1'b1;
                end
                if (wr_cmp_lo_c) begin
                    cmp_lo_buf <= din;
                end
                if (wr_cmp_hi_c) begin
                    cmp <= {din[HI_W-1:0], cmp_lo_buf};
                end
                if (rd_cnt_lo_c) begin
                    cnt_hi_shadow <= cnt[COUNTER_WIDTH-1:8];
                end
            end
        end

        always_comb begin
            rdata_c = 8'h00;
            case (reg_sel_c)
                REG_CTRL:   rdata_c = {3'b000, fast, 1'b0, irq_en, oneshot, en} & 8'h17;
                REG_STATUS: rdata_c = {7'b0000000, flag};
                REG_CNT_LO: rdata_c = cnt[7:0];
                REG_CNT_HI: rdata_c = 8'(cnt_hi_shadow);
                REG_CMP_LO: rdata_c = cmp_lo_buf;
                REG_CMP_HI: rdata_c = 8'(cmp[COUNTER_WIDTH-1:8]);
                default:    rdata_c = 8'h00;
            endcase
        end

        assign ch_rdata[i]  = rdata_c;
        assign irq_terms[i] = flag && irq_en;
    end

    always_comb begin
        rd_mux_c = 8'h00;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (ch_sel_c == ADDR_W'(c)) begin
                rd_mux_c = ch_rdata[c];
            end
        end
    end

    // Registered read data and combined interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout <= '0;
            irq  <= 1'b0;
        end else begin
            if (rd) begin
                dout <= rd_mux_c;
            end
            irq <= |irq_terms;
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed scenarios plus randomized register traffic against a
// spec-level reference model of timer_bank (INTERVAL shortened to 3).
module tb_timer_bank;

    localparam int unsigned CH = 4;
    localparam int unsigned CW = 16;
    localparam int unsigned DW = 15;
    localparam int unsigned IV = 3;
    localparam int unsigned AW = $clog2(CH) + 3;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] addr    = '0;
    logic          wr      = 1'b0;
    logic          rd      = 1'b0;
    logic [7:0]    din     = 8'h00;
    logic [7:0]    dout;
    logic          irq;

    timer_bank #(
        .CHANNELS     (CH),
        .COUNTER_WIDTH(CW),
        .DIVIDER_WIDTH(DW),
        .INTERVAL     (15'(IV))
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .addr   (addr),
        .wr     (wr),
        .rd     (rd),
        .din    (din),
        .dout   (dout),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state; m_n is the index of the next clock edge since reset release
    int m_n;
    int m_cnt [CH];
    int m_cmp [CH];
    int m_buf [CH];
    int m_sh  [CH];
    bit m_en  [CH];
    bit m_os  [CH];
    bit m_ie  [CH];
    bit m_fast[CH];
    bit m_flag[CH];
    int m_dout;
    bit m_irq;

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_cnt[c] = 0; m_cmp[c] = 0; m_buf[c] = 0; m_sh[c] = 0;
            m_en[c] = 0; m_os[c] = 0; m_ie[c] = 0; m_fast[c] = 0; m_flag[c] = 0;
        end
        m_dout = 0;
        m_irq  = 0;
        m_n    = 0;
    endfunction

    function automatic int model_read(input int a);
        int ch;
        int rg;
        ch = a >> 3;
        rg = a & 7;
        if (ch >= CH) return 0;
        case (rg)
            0: return (int'(m_fast[ch]) << 4) | (int'(m_ie[ch]) << 2) |
                      (int'(m_os[ch]) << 1) | int'(m_en[ch]);
            1: return int'(m_flag[ch]);
            2: return m_cnt[ch] & 255;
            3: return m_sh[ch];
            4: return m_buf[ch];
            5: return m_cmp[ch] >> 8;
            default: return 0;
        endcase
    endfunction

    function automatic void model_step(input bit w, input bit r, input int a, input int d);
        bit tick;
        bit nirq;
        bit hit[CH];
        int ch;
        int rg;
        tick = ((m_n % (IV + 1)) == IV);
        m_n++;
        ch = a >> 3;
        rg = a & 7;
        nirq = 0;
        for (int c = 0; c < CH; c++) if (m_flag[c] && m_ie[c]) nirq = 1;
        if (r) begin
            m_dout = model_read(a);
            if (rg == 2 && ch < CH) m_sh[ch] = m_cnt[ch] >> 8;
        end
        for (int c = 0; c < CH; c++) begin
            hit[c] = 0;
            if (m_en[c] && (tick || m_fast[c])) begin
                if (m_cnt[c] == m_cmp[c]) begin
                    hit[c] = 1;
                    if (m_os[c]) m_en[c] = 0;
                    else m_cnt[c] = 0;
                end else begin
                    m_cnt[c] = (m_cnt[c] + 1) % (1 << CW);
                end
            end
        end
        if (w && ch < CH) begin
            case (rg)
                0: begin
                    m_en[ch] = (d & 1) != 0;
                    m_os[ch] = (d & 2) != 0;
                    m_ie[ch] = (d & 4) != 0;
                    if ((d & 8) != 0) m_cnt[ch] = 0;
`ifdef TIMER_BANK_FASTCLK_EN
                    m_fast[ch] = (d & 16) != 0;
`endif
                end
                1: if ((d & 1) != 0) m_flag[ch] = 0;
                4: m_buf[ch] = d;
                5: m_cmp[ch] = (d << 8) | m_buf[ch];
                default: ;
            endcase
        end
        for (int c = 0; c < CH; c++) if (hit[c]) m_flag[c] = 1;
        m_irq = nirq;
    endfunction

    // The only way the bench advances the clock, so the model stays in lock-step
    task automatic drive(input bit w, input bit r, input int a, input int d);
        wr   = w;
        rd   = r;
        addr = AW'(a);
        din  = 8'(d);
        @(posedge clk);
        model_step(w, r, a, d);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0);
    endtask

    task automatic idle_to(input int t);
        while (m_n < t) drive(0, 0, 0, 0);
    endtask

    task automatic align_tick();
        while ((m_n % (IV + 1)) != IV) drive(0, 0, 0, 0);
    endtask

    task automatic wreg(input int a, input int d);
        drive(1, 0, a, d);
    endtask

    task automatic rreg(input int a);
        drive(0, 1, a, 0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %02h expected 00", dout); end
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq); end
        #20;
        reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < CH; c++) begin
            for (int rg = 0; rg < 7; rg++) begin
                rreg(c * 8 + rg);
                n_vec++;
                if (dout !== 8'h00) begin
                    n_err++;
                    $display("FAIL reset_reg ch%0d r%0d: got %02h expected 00", c, rg, dout);
                end
            end
        end
    endtask

    task automatic test_periodic_irq();
        int e;
        wreg(4, 5);
        wreg(5, 0);
        align_tick();
        e = m_n;
        wreg(0, 8'h05);
        idle_to(e + 25);
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL periodic_irq_early: got %b expected 0", irq); end
        idle(1);
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL periodic_irq_rise: got %b expected 1", irq); end
        rreg(1);
        n_vec++;
        if (dout !== 8'h01) begin n_err++; $display("FAIL periodic_flag: got %02h expected 01", dout); end
        rreg(2);
        n_vec++;
        if (dout !== 8'h00) begin n_err++; $display("FAIL periodic_cnt_wrap: got %02h expected 00", dout); end
        wreg(1, 8'h01);
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL periodic_irq_hold: got %b expected 1", irq); end
        idle(1);
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL periodic_irq_fall: got %b expected 0", irq); end
    endtask

    task automatic test_oneshot();
        int e;
        wreg(12, 2);
        wreg(13, 0);
        align_tick();
        e = m_n;
        wreg(8, 8'h03);
        idle_to(e + 13);
        rreg(9);
        n_vec++;
        if (dout !== 8'h01) begin n_err++; $display("FAIL oneshot_flag: got %02h expected 01", dout); end
        rreg(10);
        n_vec++;
        if (dout !== 8'h02) begin n_err++; $display("FAIL oneshot_cnt: got %02h expected 02", dout); end
        rreg(8);
        n_vec++;
        if (dout !== 8'h02) begin n_err++; $display("FAIL oneshot_ctrl: got %02h expected 02", dout); end
        idle(8);
        rreg(10);
        n_vec++;
        if (dout !== 8'h02) begin n_err++; $display("FAIL oneshot_hold: got %02h expected 02", dout); end
    endtask

    task automatic test_atomic_read();
        int e;
        wreg(20, 8'hFF);
        wreg(21, 8'hFF);
        align_tick();
        e = m_n;
        wreg(16, 8'h01);
        idle_to(e + 1023);
        rreg(18);
        n_vec++;
        if (dout !== 8'hFF) begin n_err++; $display("FAIL atomic_lo: got %02h expected ff", dout); end
        rreg(19);
        n_vec++;
        if (dout !== 8'h00) begin n_err++; $display("FAIL atomic_hi_shadow: got %02h expected 00", dout); end
        rreg(18);
        n_vec++;
        if (dout !== 8'h00) begin n_err++; $display("FAIL atomic_lo2: got %02h expected 00", dout); end
        rreg(19);
        n_vec++;
        if (dout !== 8'h01) begin n_err++; $display("FAIL atomic_hi2: got %02h expected 01", dout); end
    endtask

    task automatic test_cmp_buffer();
        wreg(28, 3);
        wreg(29, 0);
        wreg(24, 8'h01);
        idle(40);
        wreg(25, 1);
        wreg(28, 8'h34);
        rreg(28);
        n_vec++;
        if (dout !== 8'h34) begin n_err++; $display("FAIL cmpbuf_lo: got %02h expected 34", dout); end
        rreg(29);
        n_vec++;
        if (dout !== 8'h00) begin n_err++; $display("FAIL cmpbuf_hi_old: got %02h expected 00", dout); end
        idle(20);
        rreg(25);
        n_vec++;
        if (dout !== 8'h01) begin n_err++; $display("FAIL cmpbuf_old_match: got %02h expected 01", dout); end
        wreg(29, 8'h12);
        rreg(29);
        n_vec++;
        if (dout !== 8'h12) begin n_err++; $display("FAIL cmpbuf_hi_new: got %02h expected 12", dout); end
        wreg(25, 1);
        idle(40);
        rreg(25);
        n_vec++;
        if (dout !== 8'(model_read(25)) || dout !== 8'h00) begin
            n_err++; $display("FAIL cmpbuf_new_nomatch: got %02h expected 00", dout);
        end
    endtask

    task automatic test_simultaneous();
        int e;
        wreg(9, 1);
        wreg(12, 3);
        wreg(13, 0);
        align_tick();
        e = m_n;
        wreg(8, 8'h09);
        idle_to(e + 16);
        wreg(9, 1);
        rreg(9);
        n_vec++;
        if (dout !== 8'h01) begin n_err++; $display("FAIL simul_set_beats_w1c: got %02h expected 01", dout); end
        wreg(9, 1);
        rreg(9);
        n_vec++;
        if (dout !== 8'h00) begin n_err++; $display("FAIL simul_w1c: got %02h expected 00", dout); end
        idle_to(e + 24);
        wreg(8, 8'h09);
        rreg(10);
        n_vec++;
        if (dout !== 8'h00) begin n_err++; $display("FAIL simul_clr_beats_tick: got %02h expected 00", dout); end
        idle_to(e + 29);
        rreg(10);
        n_vec++;
        if (dout !== 8'h01) begin n_err++; $display("FAIL simul_restart: got %02h expected 01", dout); end
        idle_to(e + 40);
        wreg(8, 8'h09);
        rreg(9);
        n_vec++;
        if (dout !== 8'h01) begin n_err++; $display("FAIL simul_clr_match_flag: got %02h expected 01", dout); end
        rreg(10);
        n_vec++;
        if (dout !== 8'h00) begin n_err++; $display("FAIL simul_clr_match_cnt: got %02h expected 00", dout); end
    endtask

    task automatic test_fast();
`ifdef TIMER_BANK_FASTCLK_EN
        int e;
        wreg(20, 9);
        wreg(21, 0);
        wreg(16, 8'h08);
        wreg(17, 1);
        e = m_n;
        wreg(16, 8'h11);
        idle_to(e + 10);
        rreg(17);
        n_vec++;
        if (dout !== 8'h00) begin n_err++; $display("FAIL fast_flag_early: got %02h expected 00", dout); end
        rreg(17);
        n_vec++;
        if (dout !== 8'h01) begin n_err++; $display("FAIL fast_flag_set: got %02h expected 01", dout); end
        rreg(16);
        n_vec++;
        if (dout !== 8'h11) begin n_err++; $display("FAIL fast_ctrl: got %02h expected 11", dout); end
`else
        wreg(16, 8'h10);
        rreg(16);
        n_vec++;
        if (dout !== 8'h00) begin n_err++; $display("FAIL fast_absent_ctrl: got %02h expected 00", dout); end
`endif
    endtask

    task automatic test_async_reset();
        rreg(0);
        n_vec++;
        if (dout !== 8'h05) begin n_err++; $display("FAIL areset_pre: got %02h expected 05", dout); end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (dout !== 8'h00) begin n_err++; $display("FAIL areset_dout: got %02h expected 00", dout); end
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL areset_irq: got %b expected 0", irq); end
        #20;
        reset_n = 1'b1;
        model_reset();
        // cmp is 0 after reset: periodic channel flags on every tick, first tick at edge IV
        wreg(0, 8'h01);
        idle_to(IV);
        rreg(1);
        n_vec++;
        if (dout !== 8'h00) begin n_err++; $display("FAIL areset_pre_tick: got %02h expected 00", dout); end
        rreg(1);
        n_vec++;
        if (dout !== 8'h01) begin n_err++; $display("FAIL areset_first_tick: got %02h expected 01", dout); end
        rreg(2);
        n_vec++;
        if (dout !== 8'h00) begin n_err++; $display("FAIL areset_cmp0_cnt: got %02h expected 00", dout); end
        for (int c = 1; c < CH; c++) begin
            rreg(c * 8 + 5);
            n_vec++;
            if (dout !== 8'h00) begin n_err++; $display("FAIL areset_cmp ch%0d: got %02h expected 00", c, dout); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            int a;
            int d;
            bit w;
            bit r;
            w = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 1) == 1);
            a = int'($urandom_range(0, 31));
            d = int'($urandom_range(0, 255));
            if ((a & 7) == 5) d = ($urandom_range(0, 7) == 0) ? d : 0;
            if ((a & 7) == 4) d = int'($urandom_range(0, 12));
            if ((a & 7) == 0 && $urandom_range(0, 3) != 0) d = d & ~8;
            drive(w, r, a, d);
            n_vec++;
            if (dout !== 8'(m_dout)) begin
                n_err++;
                $display("FAIL random_dout @%0d a=%0d: got %02h expected %02h", i, a, dout, 8'(m_dout));
            end
            n_vec++;
            if (irq !== m_irq) begin
                n_err++;
                $display("FAIL random_irq @%0d: got %b expected %b", i, irq, m_irq);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_periodic_irq();
        test_oneshot();
        test_atomic_read();
        test_cmp_buffer();
        test_simultaneous();
        test_fast();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
